plab4_net_router_input_ctrl_arb_rr: RTL and testbench

//  Per-input-port controller for a router whose input port holds one buffer per security domain.

---
 rtl/plab4_net_router_input_ctrl_arb_rr_if.sv | 26 ++
 rtl/plab4_net_router_input_ctrl_arb_rr.sv | 141 ++++++++++++++
 tb/tb_plab4_net_router_input_ctrl_arb_rr.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/plab4_net_router_input_ctrl_arb_rr_if.sv
// Handshake bundle between one router input port (domain buffers + output arbiters)
// and its input controller.
interface plab4_net_router_input_ctrl_arb_rr_if #(
  parameter int p_num_routers = 8,
  parameter int p_num_domains = 2
);
  localparam int c_dest_nbits = $clog2(p_num_routers);
  localparam int c_dom_nbits  = $clog2(p_num_domains);

  logic [p_num_domains*c_dest_nbits-1:0] dest;
  logic [p_num_domains-1:0]              in_val;
  logic [p_num_domains-1:0]              in_rdy;
  logic [2:0]                            reqs;
  logic [2:0]                            grants;
  logic [c_dom_nbits-1:0]                domain;

  modport master (
    output dest, in_val, grants,
    input  in_rdy, reqs, domain
  );

  modport slave (
    input  dest, in_val, grants,
    output in_rdy, reqs, domain
  );
endinterface

// File: rtl/plab4_net_router_input_ctrl_arb_rr.sv
// Input-port controller: ring route per domain head flit, one domain chosen per cycle
// by a round-robin pointer with a hold register and a hold timeout.
module plab4_net_router_input_ctrl_arb_rr #(
  parameter int p_router_id   = 0,
  parameter int p_num_routers = 8,
  parameter int p_num_domains = 2,
  parameter int p_max_hold    = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  plab4_net_router_input_ctrl_arb_rr_if.slave ctl_if
);
  localparam int c_dest_nbits = $clog2(p_num_routers);
  localparam int c_dom_nbits  = $clog2(p_num_domains);
  localparam int c_cnt_nbits  = $clog2(p_max_hold + 1);

  typedef enum logic {ST_IDLE, ST_HELD} state_t;

  state_t                 state_q, state_d;
  logic [c_dom_nbits-1:0] rr_ptr_q, rr_ptr_d;
  logic [c_dom_nbits-1:0] hold_dom_q, hold_dom_d;
  logic [c_cnt_nbits-1:0] wait_cnt_q, wait_cnt_d;

  logic [2:0]             route_req [p_num_domains];
  logic [c_dom_nbits-1:0] sel;
  logic [2:0]             reqs_w;
  logic [p_num_domains-1:0] in_rdy_w;
  logic                   xfer;
  logic                   any_val;

  function automatic logic [c_dom_nbits-1:0] inc_dom(input logic [c_dom_nbits-1:0] x);
    if (int'(x) == p_num_domains - 1) return '0;
    return x + 1'b1;
  endfunction

  // Shortest-way ring routing; the exact half-way distance goes east.
  for (genvar gi = 0; gi < p_num_domains; gi++) begin : g_route
    logic [c_dest_nbits-1:0] dst;
    logic [2:0]              req;
    int                      fwd;

    assign dst = ctl_if.dest[gi*c_dest_nbits +: c_dest_nbits];

    always_comb begin
      fwd = int'(dst) - p_router_id;
      if (fwd < 0) fwd = fwd + p_num_routers;
      req = 3'b000;
      if (ctl_if.in_val[gi]) begin
        if (fwd == 0)                    req = 3'b010;
        else if (fwd <= p_num_routers/2) req = 3'b100;
        else                             req = 3'b001;
      end
    end

    assign route_req[gi] = req;
  end

  // Reverse scan so the valid domain closest to rr_ptr is the one that sticks.
  always_comb begin
    int                     idx;
    logic [c_dom_nbits-1:0] idx_n;
    idx     = 0;
    idx_n   = '0;
    sel     = rr_ptr_q;
    any_val = |ctl_if.in_val;
    if (state_q == ST_HELD) begin
      sel = hold_dom_q;
    end else begin
      for (int k = p_num_domains - 1; k >= 0; k--) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= p_num_domains) idx = idx - p_num_domains;
        idx_n = c_dom_nbits'(idx);
        if (ctl_if.in_val[idx_n]) sel = idx_n;
      end
    end
  end

  assign reqs_w = route_req[sel];
  assign xfer   = |(reqs_w & ctl_if.grants);

  always_comb begin
    in_rdy_w = '0;
    if (xfer) in_rdy_w[sel] = 1'b1;
  end

  assign ctl_if.reqs   = reqs_w;
  assign ctl_if.domain = sel;
  assign ctl_if.in_rdy = in_rdy_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      hold_dom_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_dom_q <= hold_dom_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // In HELD, a transfer beats a valid drop, which beats the timeout.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    hold_dom_d = hold_dom_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_val) begin
          if (xfer) begin
            rr_ptr_d = inc_dom(sel);
          end else begin
            state_d    = ST_HELD;
            hold_dom_d = sel;
            wait_cnt_d = c_cnt_nbits'(1);
          end
        end
      end
      ST_HELD: begin
        if (xfer) begin
          state_d    = ST_IDLE;
          rr_ptr_d   = inc_dom(hold_dom_q);
          wait_cnt_d = '0;
        end else if (!ctl_if.in_val[hold_dom_q]) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == c_cnt_nbits'(p_max_hold)) begin
          state_d    = ST_IDLE;
          rr_ptr_d   = inc_dom(hold_dom_q);
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_plab4_net_router_input_ctrl_arb_rr.sv
// Bench for the input controller: directed ring-route / round-robin / timeout / reset
// sequences, then random traffic checked against a reference model of the rules.
module tb_plab4_net_router_input_ctrl_arb_rr;
  localparam int ID = 6;
  localparam int NR = 8;
  localparam int ND = 3;
  localparam int MH = 4;
  localparam int DB = $clog2(NR);

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;

  int   m_rr, m_hdom, m_wait;
  bit   m_hold;
  logic [ND-1:0] last_rdy;

  plab4_net_router_input_ctrl_arb_rr_if #(.p_num_routers(NR), .p_num_domains(ND)) rif ();

  plab4_net_router_input_ctrl_arb_rr #(
    .p_router_id(ID), .p_num_routers(NR), .p_num_domains(ND), .p_max_hold(MH)
  ) dut (
    .clk(clk), .reset(reset), .ctl_if(rif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (txn %0d)", tag, got, exp, txn);
    end
  endtask

  function automatic logic [2:0] route(input int dst);
    int fwd;
    if (dst == ID) return 3'b010;
    fwd = (dst - ID + NR) % NR;
    return (fwd <= NR/2) ? 3'b100 : 3'b001;
  endfunction

  function automatic logic [ND*DB-1:0] pk(input int a, input int b, input int c);
    return {DB'(c), DB'(b), DB'(a)};
  endfunction

  task automatic step(input bit rst, input logic [ND-1:0] v, input logic [ND*DB-1:0] ds,
                      input logic [2:0] g);
    int         sel;
    bit         found;
    logic [2:0] er;
    logic [ND-1:0] erdy;
    bit         xf;
    @(posedge clk);
    #1;
    reset = rst; rif.in_val = v; rif.dest = ds; rif.grants = g;
    @(negedge clk);
    txn++;
    if (m_hold) sel = m_hdom;
    else begin
      sel = m_rr; found = 0;
      for (int k = 0; k < ND; k++)
        if (!found && v[(m_rr + k) % ND]) begin sel = (m_rr + k) % ND; found = 1; end
    end
    er   = v[sel] ? route(int'(ds[sel*DB +: DB])) : 3'b000;
    xf   = |(er & g);
    erdy = '0;
    if (xf) erdy[sel] = 1'b1;
    $display("txn %0d rst=%0b val=%b g=%b -> dom=%0d reqs=%b rdy=%b", txn, rst, v, g,
             rif.domain, rif.reqs, rif.in_rdy);
    check("reqs", 32'(rif.reqs), 32'(er));
    check("domain", 32'(rif.domain), 32'(sel));
    check("in_rdy", 32'(rif.in_rdy), 32'(erdy));
    last_rdy = erdy;
    if (rst) begin
      m_rr = 0; m_hold = 0; m_hdom = 0; m_wait = 0;
    end else if (!m_hold) begin
      if (v != 0) begin
        if (xf) m_rr = (sel + 1) % ND;
        else begin m_hold = 1; m_hdom = sel; m_wait = 1; end
      end
    end else begin
      if (xf) begin m_hold = 0; m_rr = (m_hdom + 1) % ND; m_wait = 0; end
      else if (!v[m_hdom]) begin m_hold = 0; m_wait = 0; end
      else if (m_wait == MH) begin m_hold = 0; m_rr = (m_hdom + 1) % ND; m_wait = 0; end
      else m_wait++;
    end
  endtask

  initial begin
    logic [ND-1:0]    vals;
    logic [ND*DB-1:0] ds;
    logic [2:0]       g;
    reset = 1'b1; rif.in_val = '0; rif.dest = '0; rif.grants = '0;
    repeat (2) @(posedge clk);
    m_rr = 0; m_hold = 0; m_hdom = 0; m_wait = 0; last_rdy = '0;

    step(1, '0, '0, 3'b000);
    check("rst_domain", 32'(rif.domain), 0);
    check("rst_reqs", 32'(rif.reqs), 0);

    // Routes from router 6 on an 8-ring, d0 held ungranted while its dest changes.
    step(0, 3'b001, pk(1, 0, 0), 3'b000);
    check("route_d1", 32'(rif.reqs), 32'(3'b100));
    step(0, 3'b001, pk(2, 0, 0), 3'b000);
    check("route_tie", 32'(rif.reqs), 32'(3'b100));
    step(0, 3'b001, pk(3, 0, 0), 3'b000);
    check("route_west", 32'(rif.reqs), 32'(3'b001));
    step(0, 3'b001, pk(6, 0, 0), 3'b000);
    check("route_term", 32'(rif.reqs), 32'(3'b010));
    step(0, 3'b001, pk(6, 0, 0), 3'b010);
    check("hold_grant", 32'(rif.in_rdy), 32'(3'b001));

    // Alternation with both domains valid and every grant matching.
    for (int i = 0; i < 4; i++) begin
      step(0, 3'b011, pk(6, 7, 0), 3'b111);
      check("alt_dom", 32'(rif.domain), (i % 2 == 0) ? 1 : 0);
    end

    // Hold timeout on d1, then the pointer moves past it.
    for (int i = 0; i < MH + 1; i++) begin
      step(0, 3'b011, pk(6, 7, 0), 3'b000);
      check("to_hold", 32'(rif.domain), 1);
    end
    step(0, 3'b011, pk(6, 7, 0), 3'b111);
    check("to_release", 32'(rif.domain), 0);

    // Reset while holding d2 drops the hold and rewinds the pointer.
    step(0, 3'b101, pk(6, 7, 0), 3'b000);
    check("hold_d2", 32'(rif.domain), 2);
    step(1, 3'b000, pk(6, 7, 0), 3'b000);
    step(0, 3'b101, pk(6, 7, 0), 3'b111);
    check("post_rst_dom", 32'(rif.domain), 0);
    check("post_rst_rdy", 32'(rif.in_rdy), 32'(3'b001));

    vals = '0;
    ds   = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < ND; d++) begin
        if ($urandom_range(7) == 0) vals[d] = ~vals[d];
        if ($urandom_range(3) == 0 || last_rdy[d]) ds[d*DB +: DB] = DB'($urandom_range(NR - 1));
      end
      g = ($urandom_range(9) < 4) ? 3'b000 : 3'($urandom_range(7));
      if ($urandom_range(149) == 0) step(1, '0, ds, g);
      else                          step(0, vals, ds, g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
